rt_pixel_seq: RTL and testbench

//   Initiator side of the rt_rgu request interface: walks a W x H frame in raster

---
 rtl/rt_pkg.sv | 20 ++
 rtl/rt_raster_counter.sv | 45 ++++
 rtl/rt_pixel_seq.sv | 133 +++++++++++++
 tb/tb_rt_pixel_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types and helpers for the pixel sequencer
package rt_pkg;

   localparam int COORD_W   = 32;
   localparam int FRAC_BITS = 18;

   typedef logic [COORD_W-1:0] fix_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   function automatic fix_t to_fix(input int unsigned v);
      return fix_t'(v) << FRAC_BITS;
   endfunction

endpackage

// File: rtl/rt_raster_counter.sv
// rtl/rt_raster_counter.sv - latched frame dimensions and raster x/y walk
module rt_raster_counter #(
   parameter int DIM_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   input  logic             step,
   output logic [DIM_W-1:0] x,
   output logic [DIM_W-1:0] y,
   output logic             last
);
   import rt_pkg::*;

   logic [DIM_W-1:0] w_q;
   logic [DIM_W-1:0] h_q;
   logic             x_wrap;

   assign x_wrap = (x == w_q - DIM_W'(1));
   assign last   = x_wrap && (y == h_q - DIM_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         w_q <= '0;
         h_q <= '0;
         x   <= '0;
         y   <= '0;
      end else if (load) begin
         w_q <= width;
         h_q <= height;
         x   <= '0;
         y   <= '0;
      end else if (step) begin
         if (x_wrap) begin
            x <= '0;
            y <= y + DIM_W'(1);
         end else begin
            x <= x + DIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/rt_pixel_seq.sv
// rtl/rt_pixel_seq.sv - raster pixel issue to the RGU with credit flow control
module rt_pixel_seq #(
   parameter int COORD_W   = 32,
   parameter int FRAC_BITS = 18,
   parameter int DIM_W     = 12,
   parameter int CREDITS   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIM_W-1:0]   cfg_width,
   input  logic [DIM_W-1:0]   cfg_height,
   input  logic               frame_start,
   output logic               frame_busy,
   output logic               frame_done,
   output logic               rgu_start,
   output logic [COORD_W-1:0] rgu_x,
   output logic [COORD_W-1:0] rgu_y,
   input  logic               rgu_valid,
   input  logic               ray_ack,
   output logic               err
);
   import rt_pkg::*;

   localparam int CRED_W = $clog2(CREDITS + 1);
   localparam int CNT_W  = 2 * DIM_W;
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

   if (DIM_W + FRAC_BITS > COORD_W - 1) begin : g_coord_width_bad
      $error("rt_pixel_seq: DIM_W + FRAC_BITS must fit below the sign bit of COORD_W");
   end
   if (CREDITS < 1) begin : g_credits_bad
      $error("rt_pixel_seq: CREDITS must be at least 1");
   end

   seq_state_e        state_q, state_d;
   logic [CRED_W-1:0] inflight_q;
   logic [CNT_W-1:0]  returned_q;
   logic [CNT_W-1:0]  total_q;
   logic              issue;
   logic              accept;
   logic              active;
   logic [DIM_W-1:0]  px, py;
   logic              px_last;

   assign accept = (state_q == IDLE) && frame_start;
   assign active = (state_q != IDLE);

   rt_raster_counter #(.DIM_W(DIM_W)) u_raster (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .width  (cfg_width),
      .height (cfg_height),
      .step   (issue),
      .x      (px),
      .y      (py),
      .last   (px_last)
   );

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start)
               state_d = (cfg_width == '0 || cfg_height == '0) ? DONE : RUN;
         end
         RUN: begin
            if (inflight_q < CRED_MAX) begin
               issue = 1'b1;
               if (px_last)
                  state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (returned_q == total_q && inflight_q == '0)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs follow the state register by one cycle so that every
   // port comes straight from a flop; busy overlaps the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         inflight_q <= '0;
         returned_q <= '0;
         total_q    <= '0;
         err        <= 1'b0;
         rgu_start  <= 1'b0;
         rgu_x      <= '0;
         rgu_y      <= '0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         rgu_start  <= issue;
         frame_busy <= active;
         frame_done <= (state_q == DONE);

         if (issue) begin
            rgu_x <= {{(COORD_W-DIM_W-FRAC_BITS){1'b0}}, px, {FRAC_BITS{1'b0}}};
            rgu_y <= {{(COORD_W-DIM_W-FRAC_BITS){1'b0}}, py, {FRAC_BITS{1'b0}}};
         end

         if (accept) begin
            total_q    <= CNT_W'(cfg_width) * CNT_W'(cfg_height);
            returned_q <= '0;
         end else if (active && rgu_valid) begin
            if (returned_q == total_q)
               err <= 1'b1;
            else
               returned_q <= returned_q + CNT_W'(1);
         end

         // Returns while IDLE belong to an aborted frame and are dropped.
         if (active) begin
            if (issue && !ray_ack) begin
               inflight_q <= inflight_q + CRED_W'(1);
            end else if (!issue && ray_ack) begin
               if (inflight_q == '0)
                  err <= 1'b1;
               else
                  inflight_q <= inflight_q - CRED_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rt_pixel_seq.sv
// tb/tb_rt_pixel_seq.sv - directed self-checking bench for rt_pixel_seq
module tb_rt_pixel_seq;
   import rt_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] cfg_width, cfg_height;
   logic        frame_start;
   logic        valid8, ack8, valid2, ack2;
   logic        busy8, done8, start8, err8;
   logic        busy2, done2, start2, err2;
   logic [31:0] x8, y8, x2, y2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rt_pixel_seq #(.COORD_W(32), .FRAC_BITS(18), .DIM_W(12), .CREDITS(8)) dut8 (
      .clk(clk), .reset(reset), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .frame_start(frame_start), .frame_busy(busy8), .frame_done(done8),
      .rgu_start(start8), .rgu_x(x8), .rgu_y(y8), .rgu_valid(valid8),
      .ray_ack(ack8), .err(err8)
   );

   rt_pixel_seq #(.COORD_W(32), .FRAC_BITS(18), .DIM_W(12), .CREDITS(2)) dut2 (
      .clk(clk), .reset(reset), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .frame_start(frame_start), .frame_busy(busy2), .frame_done(done2),
      .rgu_start(start2), .rgu_x(x2), .rgu_y(y2), .rgu_valid(valid2),
      .ray_ack(ack2), .err(err2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; frame_start = 1'b0;
      valid8 = 1'b0; ack8 = 1'b0; valid2 = 1'b0; ack2 = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic begin_frame(input int w, input int h);
      cfg_width = 12'(w); cfg_height = 12'(h);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic watch(input int n, input bit sel2, output int cnt, output logic [31:0] lx);
      cnt = 0; lx = 'x;
      for (int i = 0; i < n; i++) begin
         tick();
         if (sel2 ? start2 : start8) begin
            cnt++;
            lx = sel2 ? x2 : x8;
         end
      end
   endtask

   task automatic wait_done8(input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (done8) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // RGU model answering each issued pixel with valid+ack on the next cycle.
   task automatic run_auto(input int w, input int h, input bit poke);
      int c, npix, pend, sent, first, last, done_c, sent_at_done;
      c = 1; npix = 0; pend = 0; sent = 0; first = -1; last = -1;
      done_c = -1; sent_at_done = -1;
      begin_frame(w, h);
      while (done_c < 0 && c < 80) begin
         if (start8) begin
            chk("pix_x", x8, to_fix(npix % w));
            chk("pix_y", y8, to_fix(npix / w));
            if (first < 0) first = c;
            last = c;
            npix++;
            pend++;
         end
         if (done8) begin
            done_c = c;
            sent_at_done = sent;
         end else begin
            valid8 = (pend > 0);
            ack8   = (pend > 0);
            if (pend > 0) begin
               pend--;
               sent++;
            end
            frame_start = poke && (c == 3);
            cfg_width   = (poke && c == 3) ? 12'd7 : 12'(w);
            tick();
            c++;
         end
      end
      valid8 = 1'b0; ack8 = 1'b0; frame_start = 1'b0;
      chk("done_seen", 32'(done_c > 0), 32'd1);
      chk("pix_count", 32'(npix), 32'(w * h));
      chk("returns_before_done", 32'(sent_at_done), 32'(w * h));
      chk("first_latency", 32'(first), 32'd2);
      chk("burst_len", 32'(last - first), 32'(w * h - 1));
      chk("busy_at_done", 32'(busy8), 32'd1);
      tick();
      chk("done_pulse_end", 32'(done8), 32'd0);
      chk("busy_end", 32'(busy8), 32'd0);
   endtask

   initial begin
      int cnt;
      int sc;
      bit seen;
      logic [31:0] lx;

      cfg_width = '0; cfg_height = '0;
      do_reset();
      tick();
      chk("rst_start", 32'(start8), 32'd0);
      chk("rst_x", x8, 32'd0);
      chk("rst_y", y8, 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_err", 32'(err8), 32'd0);

      // 4x1 stream, then 3x2 with a frame_start poke while busy
      run_auto(4, 1, 1'b0);
      run_auto(3, 2, 1'b1);
      chk("err_after_frames", 32'(err8), 32'd0);

      // credit cap of 2 with no acknowledgements
      do_reset();
      begin_frame(4, 1);
      watch(7, 1'b1, cnt, lx);
      chk("cred_starts", 32'(cnt), 32'd2);
      chk("cred_x_hold", x2, 32'h40000);
      chk("cred_busy", 32'(busy2), 32'd1);
      ack2 = 1'b1;
      tick();
      ack2 = 1'b0;
      watch(6, 1'b1, cnt, lx);
      chk("cred_one_more", 32'(cnt), 32'd1);
      chk("cred_x_next", lx, 32'h80000);

      // zero width frame
      do_reset();
      sc = 0;
      begin_frame(0, 5);
      sc += int'(start8);
      chk("zw_done_c1", 32'(done8), 32'd0);
      tick();
      sc += int'(start8);
      chk("zw_done_c2", 32'(done8), 32'd1);
      chk("zw_busy_c2", 32'(busy8), 32'd1);
      tick();
      sc += int'(start8);
      chk("zw_done_c3", 32'(done8), 32'd0);
      chk("zw_busy_c3", 32'(busy8), 32'd0);
      tick();
      sc += int'(start8);
      chk("zw_no_start", 32'(sc), 32'd0);

      // reset mid-frame after three pixels of a 4x4 frame
      do_reset();
      begin_frame(4, 4);
      cnt = 0;
      for (int i = 0; i < 10 && cnt < 3; i++) begin
         tick();
         if (start8) cnt++;
      end
      chk("abort_three", 32'(cnt), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_start", 32'(start8), 32'd0);
      chk("abort_x", x8, 32'd0);
      chk("abort_y", y8, 32'd0);
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_done", 32'(done8), 32'd0);
      valid8 = 1'b1; ack8 = 1'b1;
      tick();
      tick();
      valid8 = 1'b0; ack8 = 1'b0;
      tick();
      chk("stale_err", 32'(err8), 32'd0);
      chk("stale_busy", 32'(busy8), 32'd0);
      chk("stale_start", 32'(start8), 32'd0);
      run_auto(2, 1, 1'b0);

      // ack underflow while draining
      do_reset();
      begin_frame(2, 1);
      watch(2, 1'b0, cnt, lx);
      chk("uf_starts", 32'(cnt), 32'd2);
      ack8 = 1'b1;
      tick();
      tick();
      chk("uf_no_err_yet", 32'(err8), 32'd0);
      tick();
      ack8 = 1'b0;
      tick();
      chk("uf_err", 32'(err8), 32'd1);
      tick(); tick(); tick();
      chk("uf_err_sticky", 32'(err8), 32'd1);
      valid8 = 1'b1;
      tick();
      tick();
      valid8 = 1'b0;
      wait_done8(10, seen);
      chk("uf_frame_done", 32'(seen), 32'd1);
      tick();
      chk("uf_err_after_frame", 32'(err8), 32'd1);
      do_reset();
      tick();
      chk("uf_err_cleared", 32'(err8), 32'd0);

      // surplus rgu_valid
      begin_frame(2, 1);
      watch(2, 1'b0, cnt, lx);
      valid8 = 1'b1;
      tick();
      tick();
      chk("sv_no_err_yet", 32'(err8), 32'd0);
      tick();
      valid8 = 1'b0;
      tick();
      chk("sv_err", 32'(err8), 32'd1);
      ack8 = 1'b1;
      tick();
      tick();
      ack8 = 1'b0;
      wait_done8(10, seen);
      chk("sv_frame_done", 32'(seen), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
